// File: rtl/color_calc_stream_if.sv
// Stream bundle for color_calc_stream: amplitude/hue beats in, packed RGB beats out.
// The block uses the slave view; whoever drives the beats and consumes the RGB uses the master view.
interface color_calc_stream_if #(
   parameter int W        = 6,
   parameter int D        = 10,
   parameter int C        = 8,
   parameter int NUM_LEDS = 24,
   parameter int IW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
);
   logic             in_valid;
   logic             in_ready;
   logic [W+D-1:0]   amp_i;
   logic [W+D-1:0]   amp_fast_i;
   logic [D-1:0]     hue_i;
   logic             steady_i;
   logic             out_valid;
   logic             out_ready;
   logic [3*C-1:0]   rgb;
   logic             out_last;
   logic [IW-1:0]    led_idx;

   modport master (
      output in_valid, amp_i, amp_fast_i, hue_i, steady_i, out_ready,
      input  in_ready, out_valid, rgb, out_last, led_idx
   );

   modport slave (
      input  in_valid, amp_i, amp_fast_i, hue_i, steady_i, out_ready,
      output in_ready, out_valid, rgb, out_last, led_idx
   );
endinterface

// File: rtl/color_calc_stream.sv
// Pipelined hue/amplitude to RGB converter with valid/ready flow control and frame indexing.
// Define COLOR_GAMMA_EN to add a fourth, squaring gamma stage (latency 4 instead of 3).
module color_calc_stream #(
   parameter int W         = 6,
   parameter int D         = 10,
   parameter int C         = 8,
   parameter int NUM_LEDS  = 24,
   parameter int SAT_AMP   = 1638,
   parameter int LED_LIMIT = 2**D - 1
) (
   input  logic               clk,
   input  logic               rst,
   color_calc_stream_if.slave bus
);
   localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int PW = W + D + 32;
   localparam logic [D-1:0]  LIMIT    = D'(LED_LIMIT);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);

   logic advance;
   logic accept;

   logic [W+D-1:0] amp_sel;
   logic [D+2:0]   hue_x6;
   logic [PW-1:0]  amp_prod;
   logic [W+31:0]  amp_scaled;
   logic [D-1:0]   amp_sat;
   logic [D-1:0]   frac_inv;
   logic [2*D-1:0] up_prod;
   logic [2*D-1:0] dn_prod;

   logic           s1_valid_q, s1_valid_d;
   logic [2:0]     s1_sector_q, s1_sector_d;
   logic [D-1:0]   s1_frac_q, s1_frac_d;
   logic [D-1:0]   s1_lim_q, s1_lim_d;

   logic           s2_valid_q, s2_valid_d;
   logic [2:0]     s2_sector_q, s2_sector_d;
   logic           s2_zero_q, s2_zero_d;
   logic [C-1:0]   s2_mx_q, s2_mx_d;
   logic [C-1:0]   s2_uc_q, s2_uc_d;
   logic [C-1:0]   s2_dc_q, s2_dc_d;

`ifdef COLOR_GAMMA_EN
   logic           s3_valid_q, s3_valid_d;
   logic [3*C-1:0] s3_rgb_q, s3_rgb_d;
`endif

   logic           out_valid_q, out_valid_d;
   logic [3*C-1:0] rgb_q, rgb_d;
   logic [IW-1:0]  cnt_q, cnt_d;

   function automatic logic [3*C-1:0] sector_map(input logic [2:0] sector, input logic zero,
                                                 input logic [C-1:0] mx, input logic [C-1:0] uc,
                                                 input logic [C-1:0] dc);
      logic [C-1:0] r, g, b;
      r = '0;
      g = '0;
      b = '0;
      case (sector)
         3'd0:    begin r = mx; g = uc; end
         3'd1:    begin r = dc; g = mx; end
         3'd2:    begin g = mx; b = uc; end
         3'd3:    begin g = dc; b = mx; end
         3'd4:    begin r = uc; b = mx; end
         3'd5:    begin r = mx; b = dc; end
         default: ;
      endcase
      sector_map = zero ? '0 : {r, g, b};
   endfunction

`ifdef COLOR_GAMMA_EN
   function automatic logic [3*C-1:0] gamma_sq(input logic [3*C-1:0] lin);
      logic [2*C-1:0] sq;
      gamma_sq = '0;
      for (int i = 0; i < 3; i++) begin
         sq = (2*C)'(lin[i*C +: C]) * (2*C)'(lin[i*C +: C]);
         gamma_sq[i*C +: C] = C'(sq >> C);
      end
   endfunction
`endif

   // Every stage moves in lockstep; only the output register can hold the pipe back.
   assign advance      = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && advance;
   assign bus.in_ready = advance || rst;

   always_comb begin
      amp_sel    = bus.steady_i ? bus.amp_i : bus.amp_fast_i;
      hue_x6     = (D+3)'(bus.hue_i) * (D+3)'(6);
      amp_prod   = PW'(amp_sel) * PW'(SAT_AMP);
      amp_scaled = (W+32)'(amp_prod >> D);
      amp_sat    = (|amp_scaled[W+31:D]) ? '1 : amp_scaled[D-1:0];
      frac_inv   = ~s1_frac_q;
      up_prod    = (2*D)'(s1_lim_q) * (2*D)'(s1_frac_q);
      dn_prod    = (2*D)'(s1_lim_q) * (2*D)'(frac_inv);
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sector_d = s1_sector_q;
      s1_frac_d   = s1_frac_q;
      s1_lim_d    = s1_lim_q;
      s2_valid_d  = s2_valid_q;
      s2_sector_d = s2_sector_q;
      s2_zero_d   = s2_zero_q;
      s2_mx_d     = s2_mx_q;
      s2_uc_d     = s2_uc_q;
      s2_dc_d     = s2_dc_q;
`ifdef COLOR_GAMMA_EN
      s3_valid_d  = s3_valid_q;
      s3_rgb_d    = s3_rgb_q;
`endif
      out_valid_d = out_valid_q;
      rgb_d       = rgb_q;
      cnt_d       = cnt_q;

      if (advance) begin
         s1_valid_d  = accept;
         s1_sector_d = hue_x6[D+2:D];
         s1_frac_d   = hue_x6[D-1:0];
         s1_lim_d    = (amp_sat > LIMIT) ? LIMIT : amp_sat;

         s2_valid_d  = s1_valid_q;
         s2_sector_d = s1_sector_q;
         s2_zero_d   = (s1_lim_q == '0);
         s2_mx_d     = C'(s1_lim_q >> (D - C));
         s2_uc_d     = C'(up_prod >> (2*D - C));
         s2_dc_d     = C'(dn_prod >> (2*D - C));

`ifdef COLOR_GAMMA_EN
         s3_valid_d  = s2_valid_q;
         s3_rgb_d    = sector_map(s2_sector_q, s2_zero_q, s2_mx_q, s2_uc_q, s2_dc_q);
         out_valid_d = s3_valid_q;
         rgb_d       = gamma_sq(s3_rgb_q);
`else
         out_valid_d = s2_valid_q;
         rgb_d       = sector_map(s2_sector_q, s2_zero_q, s2_mx_q, s2_uc_q, s2_dc_q);
`endif
      end

      if (out_valid_q && bus.out_ready) begin
         cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sector_q <= '0;
         s1_frac_q   <= '0;
         s1_lim_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_sector_q <= '0;
         s2_zero_q   <= 1'b0;
         s2_mx_q     <= '0;
         s2_uc_q     <= '0;
         s2_dc_q     <= '0;
`ifdef COLOR_GAMMA_EN
         s3_valid_q  <= 1'b0;
         s3_rgb_q    <= '0;
`endif
         out_valid_q <= 1'b0;
         rgb_q       <= '0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sector_q <= s1_sector_d;
         s1_frac_q   <= s1_frac_d;
         s1_lim_q    <= s1_lim_d;
         s2_valid_q  <= s2_valid_d;
         s2_sector_q <= s2_sector_d;
         s2_zero_q   <= s2_zero_d;
         s2_mx_q     <= s2_mx_d;
         s2_uc_q     <= s2_uc_d;
         s2_dc_q     <= s2_dc_d;
`ifdef COLOR_GAMMA_EN
         s3_valid_q  <= s3_valid_d;
         s3_rgb_q    <= s3_rgb_d;
`endif
         out_valid_q <= out_valid_d;
         rgb_q       <= rgb_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.rgb       = rgb_q;
   assign bus.led_idx   = cnt_q;
   assign bus.out_last  = out_valid_q && (cnt_q == LAST_IDX);
endmodule

// File: tb/tb_color_calc_stream.sv
// Bench for color_calc_stream: directed conversions, randomized backpressure stream against an
// arithmetic colour model, frame indexing and mid-frame reset (NUM_LEDS = 4).
module tb_color_calc_stream;
   localparam int NL     = 4;
   localparam int BUDGET = 3000;
`ifdef COLOR_GAMMA_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   color_calc_stream_if #(.W(6), .D(10), .C(8), .NUM_LEDS(NL)) bus ();

   color_calc_stream #(.W(6), .D(10), .C(8), .NUM_LEDS(NL), .SAT_AMP(1638), .LED_LIMIT(1023)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Colour model straight from the hue-wheel rules, in plain integer arithmetic.
   function automatic logic [23:0] ref_rgb(input longint amp, input int hue);
      longint m, lim;
      int sector, frac, mx, uc, dc;
      int ch[3];
      sector = (hue * 6) / 1024;
      frac   = (hue * 6) % 1024;
      m      = (amp * 1638) / 1024;
      lim    = (m > 1023) ? 1023 : m;
      mx     = int'(lim / 4);
      uc     = int'((lim * frac) / 4096);
      dc     = int'((lim * (1023 - frac)) / 4096);
      ch     = '{0, 0, 0};
      case (sector)
         0: begin ch[0] = mx; ch[1] = uc; end
         1: begin ch[0] = dc; ch[1] = mx; end
         2: begin ch[1] = mx; ch[2] = uc; end
         3: begin ch[1] = dc; ch[2] = mx; end
         4: begin ch[0] = uc; ch[2] = mx; end
         default: begin ch[0] = mx; ch[2] = dc; end
      endcase
`ifdef COLOR_GAMMA_EN
      for (int i = 0; i < 3; i++) ch[i] = (ch[i] * ch[i]) / 256;
`endif
      return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
   endfunction

   task automatic check_reset_state(input string tag);
      check_vec({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      check_vec({tag, "_rgb"},       32'(bus.rgb), 0);
      check_vec({tag, "_out_last"},  32'(bus.out_last), 0);
      check_vec({tag, "_led_idx"},   32'(bus.led_idx), 0);
      check_vec({tag, "_in_ready"},  32'(bus.in_ready), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;
   endtask

   task automatic directed(input string tag, input int amp, input int fast, input int hue,
                           input bit st, input logic [23:0] exp);
      int lat;
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.amp_i      = 16'(amp);
      bus.amp_fast_i = 16'(fast);
      bus.hue_i      = 10'(hue);
      bus.steady_i   = st;
      bus.out_ready  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (lat < 10) begin
         @(negedge clk);
         if (bus.out_valid) break;
         @(posedge clk);
         lat++;
      end
      check_vec({tag, "_lat"}, 32'(lat), 32'(LAT));
      check_vec(tag, 32'(bus.rgb), 32'(exp));
      $display("directed %s: rgb=%06h lat=%0d", tag, bus.rgb, lat);
   endtask

   // Streams n beats; bp enables random in_valid gaps and out_ready toggling;
   // rst_at >= 0 pulses reset once that many outputs have been taken.
   task automatic run_stream(input string tag, input int n, input bit bp, input int rst_at);
      logic [23:0] q[$];
      logic [23:0] exp, prev_rgb;
      logic [1:0]  prev_idx;
      int sent = 0, got = 0, exp_idx = 0, cyc = 0;
      bit stalled_prev = 0, did_rst = 0;
      prev_rgb = '0;
      prev_idx = '0;
      while ((sent < n || q.size() > 0) && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         if (rst_at >= 0 && !did_rst && got == rst_at) begin
            rst = 1'b1;
            bus.in_valid = 1'b0;
            #1;
            check_vec({tag, "_rst_in_ready"}, 32'(bus.in_ready), 1);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check_reset_state({tag, "_midrst"});
            q.delete();
            exp_idx = 0;
            stalled_prev = 0;
            did_rst = 1;
            continue;
         end
         if (sent < n && (!bp || $urandom_range(0, 3) != 0)) begin
            bus.in_valid   = 1'b1;
            bus.amp_i      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000));
            bus.amp_fast_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000));
            bus.hue_i      = 10'($urandom_range(0, 1023));
            bus.steady_i   = 1'($urandom_range(0, 1));
         end else begin
            bus.in_valid = 1'b0;
         end
         bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         check_vec({tag, "_in_ready"}, 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
         if (stalled_prev) begin
            check_vec({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
            check_vec({tag, "_hold_rgb"}, 32'(bus.rgb), 32'(prev_rgb));
            check_vec({tag, "_hold_idx"}, 32'(bus.led_idx), 32'(prev_idx));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               check_vec({tag, "_extra_beat"}, 32'(bus.rgb), 32'hDEAD_BEEF);
            end else begin
               exp = q.pop_front();
               check_vec({tag, "_rgb"}, 32'(bus.rgb), 32'(exp));
               check_vec({tag, "_led_idx"}, 32'(bus.led_idx), 32'(exp_idx));
               check_vec({tag, "_out_last"}, 32'(bus.out_last), 32'(exp_idx == NL - 1));
               $display("%s out %0d: rgb=%06h led_idx=%0d last=%0b", tag, got, bus.rgb,
                        bus.led_idx, bus.out_last);
            end
            exp_idx = (exp_idx + 1) % NL;
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(ref_rgb(bus.steady_i ? longint'(bus.amp_i) : longint'(bus.amp_fast_i),
                                int'(bus.hue_i)));
            sent++;
         end
         stalled_prev = bus.out_valid && !bus.out_ready;
         prev_rgb     = bus.rgb;
         prev_idx     = bus.led_idx;
      end
      check_vec({tag, "_completed"}, 32'(cyc < BUDGET), 1);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (LAT + 1) @(negedge clk);
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.amp_i      = '0;
      bus.amp_fast_i = '0;
      bus.hue_i      = '0;
      bus.steady_i   = 1'b0;
      bus.out_ready  = 1'b0;
      do_reset();

`ifdef COLOR_GAMMA_EN
      directed("hue0",     0,    512,  0,   1'b0, 24'hA20000);
      directed("hue512",   0,    512,  512, 1'b0, 24'h00A2A2);
      directed("zero_amp", 0,    0,    300, 1'b0, 24'h000000);
      directed("sat",      0,    2000, 0,   1'b0, 24'hFE0000);
      directed("steady1",  512,  0,    0,   1'b1, 24'hA20000);
      directed("steady0",  512,  0,    0,   1'b0, 24'h000000);
`else
      directed("hue0",     0,    512,  0,   1'b0, 24'hCC0000);
      directed("hue512",   0,    512,  512, 1'b0, 24'h00CCCC);
      directed("zero_amp", 0,    0,    300, 1'b0, 24'h000000);
      directed("sat",      0,    2000, 0,   1'b0, 24'hFF0000);
      directed("steady1",  512,  0,    0,   1'b1, 24'hCC0000);
      directed("steady0",  512,  0,    0,   1'b0, 24'h000000);
`endif

      do_reset();
      run_stream("frame", 10, 1'b0, -1);
      do_reset();
      run_stream("bp", 40, 1'b1, -1);
      do_reset();
      run_stream("midrst", 12, 1'b0, 6);
      do_reset();
      run_stream("bp_rst", 30, 1'b1, 9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/color_calc_stream.md
Name: color_calc_stream

Overview:
- Pipelined, backpressure-aware successor to the single-note hue/amplitude-to-RGB converter.
- Accepts a stream of per-LED (amplitude, fast amplitude, hue) beats over valid/ready and emits one packed RGB word per beat.
- Supports a configurable colour depth and a fixed LED count per frame, with an end-of-frame flag.
- Sits between the note-to-LED mapper and the LED serial driver.

Parameters:
- W, 6, integer bits of amplitude inputs
- D, 10, fraction bits of amplitude and hue; must be >= C
- C, 8, output bits per colour channel (rgb width 3*C)
- NUM_LEDS, 24, beats per frame; must be >= 1
- SAT_AMP, 1638, saturation amplifier, fixed-point with D fraction bits (1638 ~ 1.6)
- LED_LIMIT, 2**D-1, upper clamp on limited amplitude

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- amp_i  in  W+D  steady amplitude
- amp_fast_i  in  W+D  fast amplitude
- hue_i  in  D  hue, 0..2^D-1 covers the full circle
- steady_i  in  1  1 selects amp_i, 0 selects amp_fast_i; sampled with the beat
- out_valid  out  1  rgb valid
- out_ready  in  1  downstream accepts
- rgb  out  3*C  {R,G,B}, R in the MSBs
- out_last  out  1  marks beat NUM_LEDS-1 of the frame
- led_idx  out  clog2(NUM_LEDS) (min 1)  index of the current output beat

Behaviour:
- Reset: out_valid=0, rgb=0, out_last=0, led_idx=0, all stage valids=0, frame counter=0.
- in_ready is high during reset and after reset.
- Pipeline: 3 stages (S1, S2, S3), each with a valid bit.
- Stall rule: advance = !out_valid || out_ready; all stages move together.
- in_ready = advance, combinational from out_ready. A beat is accepted when in_valid && in_ready.
- Latency: an accepted beat appears on out_valid 3 cycles later when there is no stall. With out_ready held high, throughput is 1 beat/cycle.
- While out_valid=1 and out_ready=0, rgb, out_last and led_idx hold stable.
- Bubbles (in_valid=0) propagate as invalid stages; there are no holes in the output stream.
- S1:
  - hp = hue_i*6 (D+3 bits); sector = hp>>D (0..5); frac = hp[D-1:0].
  - a = selected amplitude. m = (a*SAT_AMP)>>D. If m >= 2^D, m saturates to 2^D-1.
  - lim = min(m, LED_LIMIT).
- S2:
  - up = lim*frac; dn = lim*(2^D-1-frac), both 2D bits.
  - mx = lim[D-1:D-C]; uc = up[2D-1:2D-C]; dc = dn[2D-1:2D-C].
- S3 sector map (channels not listed are 0):
  - 0: R=mx, G=uc
  - 1: R=dc, G=mx
  - 2: G=mx, B=uc
  - 3: G=dc, B=mx
  - 4: R=uc, B=mx
  - 5: R=mx, B=dc
  - If lim==0, rgb=0.
- Frame counter:
  - Increments on each output handshake (out_valid && out_ready).
  - Wraps to 0 after NUM_LEDS-1.
  - led_idx = counter; out_last = out_valid && counter==NUM_LEDS-1.
  - NUM_LEDS=1: out_last is high on every valid beat.
- Simultaneous accept and emit in the same cycle is legal; no data is lost or duplicated.
- Reset mid-frame: in-flight beats are discarded, the counter returns to 0, and the next output is treated as beat 0.
- No combinational path from the input data ports to the outputs.

Optional Feature:
- Macro COLOR_GAMMA_EN.
- Defined: a 4th stage S4 applies per-channel g = (c*c)>>C. Latency becomes 4 and the stall rule extends to S4. Zero-amplitude still yields 0.
- Not defined: 3-stage pipeline, linear output, as described above.

Test Plan:
- Basic hue conversion (defaults, out_ready=1): amp_fast_i=512, steady_i=0, hue_i=0 -> rgb=CC0000 exactly 3 cycles after accept. Same amplitude with hue_i=512 -> rgb=00CCCC.
- Zero and saturation: amp_fast_i=0, any hue -> 000000. amp_fast_i=2000, hue_i=0 -> lim saturates to 1023, rgb=FF0000.
- Mode select: amp_i=512, amp_fast_i=0, steady_i=1, hue_i=0 -> CC0000. Same beat with steady_i=0 -> 000000.
- Backpressure:
  - Stream 8 beats at in_valid=1 while toggling out_ready pseudo-randomly.
  - Output sequence must equal the reference-model sequence with no drops or duplicates.
  - rgb must be stable while stalled.
  - in_ready=0 exactly when out_valid && !out_ready.
- Frame: NUM_LEDS=4, 10 beats -> out_last on outputs 3 and 7, led_idx sequence 0,1,2,3,0,1,2,3,0,1. Assert rst after output 5 -> the next output has led_idx=0.
- COLOR_GAMMA_EN defined: amp_fast_i=512, hue_i=0 -> rgb=A20000 after 4 cycles.
